// File: rtl/qr_pkg.sv
`default_nettype none
// ============================================================================
// Package : qr_pkg
// Shared frame geometry, run-window types, scan states and the finder-pattern
// ratio multipliers used by the pattern scanner and its ratio checker.
// Revision: 1.0
// ============================================================================
package qr_pkg;

    localparam int DEFAULT_WIDTH  = 480;
    localparam int DEFAULT_HEIGHT = 480;
    localparam int MAX_DIM        = 480;
    localparam int ADDR_W         = 20;
    localparam int RUN_W          = 9;
    localparam int NUM_RUNS       = 5;
    localparam int DRAIN_CYCLES   = 3;
    localparam int ARITH_W        = 16;
    localparam int MIN_TOTAL      = 7;

    // Finder pattern 1:1:3:1:1 tolerance window, expressed without division
    localparam int RATIO_UNIT     = 14;
    localparam int RATIO_UNIT_HI  = 3;
    localparam int RATIO_CTR      = 7;
    localparam int RATIO_CTR_LO   = 2;
    localparam int RATIO_CTR_HI   = 4;

    typedef logic [ADDR_W-1:0]                addr_t;
    typedef logic [RUN_W-1:0]                 run_len_t;
    typedef logic [ARITH_W-1:0]               arith_t;
    // Index 0 is the oldest run, index NUM_RUNS-1 the newest
    typedef logic [NUM_RUNS-1:0][RUN_W-1:0]   run_win_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ROW_SCAN  = 3'd1,
        ROW_DRAIN = 3'd2,
        COL_SCAN  = 3'd3,
        COL_DRAIN = 3'd4,
        DONE      = 3'd5
    } scan_state_t;

    typedef struct packed {
        logic     valid;
        logic     vert;
        logic     eol;
        run_len_t pos;
    } pix_tag_t;

endpackage
`default_nettype wire

// File: rtl/pattern_scanner_if.sv
`default_nettype none
// ============================================================================
// Interface : pattern_scanner_if
// Scan request, frame-buffer read port and finder-pattern result vectors.
// Revision: 1.0
// ============================================================================
interface pattern_scanner_if;
    import qr_pkg::*;

    logic               start;
    logic               pixel_reading;
    addr_t              address_reading;
    logic [MAX_DIM-1:0] horz_patterns;
    logic [MAX_DIM-1:0] vert_patterns;
    logic               start_cross;
    logic               busy;

    modport master (
        output start,
        output pixel_reading,
        input  address_reading,
        input  horz_patterns,
        input  vert_patterns,
        input  start_cross,
        input  busy
    );

    modport slave (
        input  start,
        input  pixel_reading,
        output address_reading,
        output horz_patterns,
        output vert_patterns,
        output start_cross,
        output busy
    );

endinterface
`default_nettype wire

// File: rtl/run_ratio_checker.sv
`default_nettype none
// ============================================================================
// Module  : run_ratio_checker
// Accepts a five-run window whose proportions match a 1:1:3:1:1 finder pattern.
// Revision: 1.0
// ============================================================================
module run_ratio_checker
    import qr_pkg::*;
(
    input  run_win_t i_runs,
    output logic     o_accept
);

    function automatic logic unit_ok(input arith_t total, input run_len_t r);
        arith_t scaled;
        scaled = arith_t'(RATIO_UNIT) * arith_t'(r);
        return (total <= scaled) && (scaled <= arith_t'(RATIO_UNIT_HI) * total);
    endfunction

    function automatic logic centre_ok(input arith_t total, input run_len_t c);
        arith_t scaled;
        scaled = arith_t'(RATIO_CTR) * arith_t'(c);
        return (arith_t'(RATIO_CTR_LO) * total <= scaled) &&
               (scaled <= arith_t'(RATIO_CTR_HI) * total);
    endfunction

    arith_t w_total;

    always_comb begin
        w_total = '0;
        for (int i = 0; i < NUM_RUNS; i++) begin
            w_total = w_total + arith_t'(i_runs[i]);
        end
    end

    assign o_accept = (w_total >= arith_t'(MIN_TOTAL))
                   && unit_ok(w_total, i_runs[0])
                   && unit_ok(w_total, i_runs[1])
                   && centre_ok(w_total, i_runs[2])
                   && unit_ok(w_total, i_runs[3])
                   && unit_ok(w_total, i_runs[4]);

endmodule
`default_nettype wire

// File: rtl/pattern_scanner.sv
`default_nettype none
// ============================================================================
// Module  : pattern_scanner
// Row-major then column-major frame scan that flags finder-pattern centres.
// Revision: 1.0
// ============================================================================
module pattern_scanner
    import qr_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int HEIGHT = DEFAULT_HEIGHT
) (
    input  logic             clk_in,
    input  logic             rst_in,
    pattern_scanner_if.slave bus
);

    localparam run_len_t   X_LAST     = run_len_t'(WIDTH - 1);
    localparam run_len_t   Y_LAST     = run_len_t'(HEIGHT - 1);
    localparam addr_t      ROW_STRIDE = addr_t'(WIDTH);
    localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);
    localparam run_len_t   VEC_LIMIT  = run_len_t'(MAX_DIM);

    scan_state_t        state_q, state_d;
    run_len_t           x_q, x_d, y_q, y_d;
    addr_t              addr_q, addr_d;
    logic [1:0]         drain_q, drain_d;
    pix_tag_t           tag0, p1_q, p1_d, p2_q, p2_d;
    run_win_t           win_q, win_d;
    run_len_t           run_start_q, run_start_d;
    logic               run_white_q, run_white_d;
    logic [MAX_DIM-1:0] horz_q, horz_d, vert_q, vert_d;
    logic               start_cross_q, start_cross_d;
    logic               busy_q, busy_d;

    logic               pix;
    run_win_t           win_adv, eval_win;
    run_len_t           start_adv, eval_start, centre_idx;
    logic               eval_en, ratio_ok, hit;

    assign pix = bus.pixel_reading;

    // Window after absorbing the current pixel (extend newest run or shift)
    always_comb begin
        win_adv   = win_q;
        start_adv = run_start_q;
        if (win_q[NUM_RUNS-1] == '0 || pix != run_white_q) begin
            win_adv   = {run_len_t'(1), win_q[NUM_RUNS-1:1]};
            start_adv = p2_q.pos;
        end else begin
            win_adv[NUM_RUNS-1] = win_q[NUM_RUNS-1] + run_len_t'(1);
        end
    end

    // A white pixel closes the black run already in the window; a black pixel
    // at end-of-line closes the run it belongs to.
    assign eval_win   = pix ? win_q : win_adv;
    assign eval_start = pix ? run_start_q : start_adv;
    assign eval_en    = p2_q.valid &&
                        (pix ? (!run_white_q && win_q[NUM_RUNS-1] != '0) : p2_q.eol);
    assign centre_idx = eval_start - eval_win[3] - eval_win[2] + (eval_win[2] >> 1);
    assign hit        = eval_en && (eval_win[0] != '0) && ratio_ok &&
                        (centre_idx < VEC_LIMIT);

    run_ratio_checker u_ratio (
        .i_runs   (eval_win),
        .o_accept (ratio_ok)
    );

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        addr_d      = addr_q;
        drain_d     = drain_q;
        win_d       = win_q;
        run_start_d = run_start_q;
        run_white_d = run_white_q;
        horz_d      = horz_q;
        vert_d      = vert_q;

        tag0.valid = (state_q == ROW_SCAN) || (state_q == COL_SCAN);
        tag0.vert  = (state_q == COL_SCAN);
        tag0.eol   = tag0.vert ? (y_q == Y_LAST) : (x_q == X_LAST);
        tag0.pos   = tag0.vert ? y_q : x_q;
        p1_d       = tag0;
        p2_d       = p1_q;

        if (p2_q.valid) begin
            win_d       = win_adv;
            run_start_d = start_adv;
            run_white_d = pix;
            if (hit) begin
                if (p2_q.vert) vert_d[centre_idx] = 1'b1;
                else           horz_d[centre_idx] = 1'b1;
            end
            if (p2_q.eol) win_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ROW_SCAN;
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
                    win_d   = '0;
                    horz_d  = '0;
                    vert_d  = '0;
                end
            end
            ROW_SCAN: begin
                addr_d = addr_q + addr_t'(1);
                if (x_q == X_LAST) begin
                    x_d = '0;
                    if (y_q == Y_LAST) begin
                        state_d = ROW_DRAIN;
                        y_d     = '0;
                        addr_d  = '0;
                        drain_d = '0;
                    end else begin
                        y_d = y_q + run_len_t'(1);
                    end
                end else begin
                    x_d = x_q + run_len_t'(1);
                end
            end
            ROW_DRAIN: begin
                drain_d = drain_q + 2'd1;
                if (drain_q == DRAIN_LAST) begin
                    state_d = COL_SCAN;
                    drain_d = '0;
                end
            end
            COL_SCAN: begin
                if (y_q == Y_LAST) begin
                    y_d = '0;
                    if (x_q == X_LAST) begin
                        state_d = COL_DRAIN;
                        x_d     = '0;
                        addr_d  = '0;
                        drain_d = '0;
                    end else begin
                        x_d    = x_q + run_len_t'(1);
                        addr_d = addr_t'(x_q) + addr_t'(1);
                    end
                end else begin
                    y_d    = y_q + run_len_t'(1);
                    addr_d = addr_q + ROW_STRIDE;
                end
            end
            COL_DRAIN: begin
                drain_d = drain_q + 2'd1;
                if (drain_q == DRAIN_LAST) begin
                    state_d = DONE;
                    drain_d = '0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        start_cross_d = (state_d == DONE);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            addr_q        <= '0;
            drain_q       <= '0;
            p1_q          <= '0;
            p2_q          <= '0;
            win_q         <= '0;
            run_start_q   <= '0;
            run_white_q   <= 1'b1;
            horz_q        <= '0;
            vert_q        <= '0;
            start_cross_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            addr_q        <= addr_d;
            drain_q       <= drain_d;
            p1_q          <= p1_d;
            p2_q          <= p2_d;
            win_q         <= win_d;
            run_start_q   <= run_start_d;
            run_white_q   <= run_white_d;
            horz_q        <= horz_d;
            vert_q        <= vert_d;
            start_cross_q <= start_cross_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.address_reading = addr_q;
    assign bus.horz_patterns   = horz_q;
    assign bus.vert_patterns   = vert_q;
    assign bus.start_cross     = start_cross_q;
    assign bus.busy            = busy_q;

endmodule
`default_nettype wire

// File: doc/pattern_scanner.md
PATTERN_SCANNER -- requirements
Module: pattern_scanner

Interface
REQ-001 SHALL have parameter WIDTH, default 480, frame width in pixels (≤480).
REQ-002 SHALL have parameter HEIGHT, default 480, frame height in pixels (≤480).
REQ-003 SHALL have port clk_in  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle scan request.
REQ-006 SHALL have port pixel_reading  input  1  binarized pixel from frame buffer; 1=white, 0=black; valid 2 cycles after address.
REQ-007 SHALL have port address_reading  output  20  frame-buffer read address = x + y*WIDTH.
REQ-008 SHALL have port horz_patterns  output  480  bit x set if a horizontal finder-pattern centre was found at column x in any row.
REQ-009 SHALL have port vert_patterns  output  480  bit y set if a vertical finder-pattern centre was found at row y in any column.
REQ-010 SHALL have port start_cross  output  1  one-cycle pulse: both vectors final; drives the downstream cross-pattern block.
REQ-011 SHALL have port busy  output  1  high from start acceptance until the start_cross pulse inclusive.

Function
REQ-012 SHALL use states IDLE, ROW_SCAN, ROW_DRAIN, COL_SCAN, COL_DRAIN, DONE; IDLE->ROW_SCAN on start; ROW_SCAN->ROW_DRAIN after last row-major address; ROW_DRAIN (3 cycles)->COL_SCAN; COL_SCAN->COL_DRAIN after last column-major address; COL_DRAIN (3 cycles)->DONE; DONE->IDLE after 1 cycle.
REQ-013 SHALL, on start accepted in IDLE, clear both pattern vectors the same cycle; start in any other state SHALL be ignored.
REQ-014 SHALL issue exactly one address per cycle in ROW_SCAN: x inner 0..WIDTH-1, y outer 0..HEIGHT-1, starting at address 0 on the cycle after acceptance.
REQ-015 SHALL issue exactly one address per cycle in COL_SCAN: y inner, x outer, same address formula.
REQ-016 SHALL carry coordinate and end-of-line flag through a 2-stage pipeline aligned to pixel_reading latency.
REQ-017 SHALL keep five 9-bit run lengths (oldest..newest) plus newest-run start coordinate; colour change shifts window and starts new run of 1.
REQ-018 SHALL evaluate the window when a black run ends (white pixel follows, or end-of-line) and the window holds five complete runs B,W,B,W,B.
REQ-019 SHALL accept with total T = sum of 5 runs, T≥7: each 1-unit run r satisfies T ≤ 14r ≤ 3T; centre run c satisfies 2T ≤ 7c ≤ 4T; arithmetic in ≥14 bits, no division.
REQ-020 SHALL, on accept, set bit (centre-run start + c>>1) of horz_patterns (row pass) or vert_patterns (column pass); bits OR-accumulate.
REQ-021 SHALL clear the run window at every end-of-line after evaluation; runs never span lines.
REQ-022 SHALL pulse start_cross for exactly one cycle in DONE, no later than 2*WIDTH*HEIGHT+10 cycles after start; vectors SHALL remain stable until the next accepted start.
REQ-023 SHALL hold address_reading at 0 outside ROW_SCAN/COL_SCAN.

Reset
REQ-024 SHALL on rst_in asynchronously force IDLE, address_reading=0, both vectors=0, start_cross=0, busy=0, run window cleared, mid-scan included.
REQ-025 SHALL after reset release accept start on the first rising edge.

Structure
REQ-026 SHALL take WIDTH/HEIGHT defaults, state enum, and ratio multipliers (14, 3, 7, 2, 4) from shared package qr_pkg.
REQ-027 SHALL instantiate one sub-module run_ratio_checker (five runs in, accept out), shared by both passes.

Verification
REQ-028 All-white frame, start -> both vectors 0, exactly one start_cross pulse, busy drops after it.
REQ-029 Row 100 pixels x=200..206 = B,W,BBB,W,B (rest white) -> horz_patterns bit 203 only; vert_patterns 0.
REQ-030 Column 40, y=50..63 = 2:2:6:2:2 (BB,WW,BBBBBB,WW,BB) -> vert_patterns bit 57 only.
REQ-031 Row pattern 1:1:1:1:1 at x=10..14, and pattern ending at x=479 (x=473..479, 1:1:3:1:1) -> bit 12 clear, bit 476 set.
REQ-032 rst_in asserted mid ROW_SCAN at address 5000 -> all outputs 0 immediately; start after release -> full scan, correct results, single start_cross.
REQ-033 Second start pulsed during COL_SCAN -> ignored; one start_cross only; address sequence uninterrupted.
